// File: rtl/node_net_pkg.sv
// Shared mesh-network definitions: default widths, transmit FSM states and header helpers.
package node_net_pkg;

  localparam int unsigned DEF_STREAM_WIDTH  = 144;
  localparam int unsigned DEF_NET_WIDTH     = 4;
  localparam int unsigned DEF_PAYLOAD_WIDTH = DEF_STREAM_WIDTH - DEF_NET_WIDTH;
  localparam int unsigned HALF_NET_WIDTH    = DEF_NET_WIDTH / 2;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_EMIT = 1'b1
  } tx_state_e;

  // Destination address occupies the top bits of every stream word.
  function automatic logic [DEF_STREAM_WIDTH-1:0] pack_header(
    input logic [DEF_NET_WIDTH-1:0]     addr,
    input logic [DEF_PAYLOAD_WIDTH-1:0] payload
  );
    return {addr, payload};
  endfunction

  function automatic logic [HALF_NET_WIDTH-1:0] addr_x(input logic [DEF_NET_WIDTH-1:0] addr);
    return addr[HALF_NET_WIDTH-1:0];
  endfunction

  function automatic logic [HALF_NET_WIDTH-1:0] addr_y(input logic [DEF_NET_WIDTH-1:0] addr);
    return addr[DEF_NET_WIDTH-1:HALF_NET_WIDTH];
  endfunction

endpackage

// File: rtl/node_tx_fifo.sv
// Payload FIFO for the packetizer: push is refused when full, even with a concurrent pop.
module node_tx_fifo #(
  parameter int unsigned WIDTH = 140,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/node_packetizer.sv
// Transmit-side node interface: prepends destination headers and fans each payload out
// to the configured destination table. NODE_PACKETIZER_STATS_EN adds a sent_count output.
module node_packetizer #(
  parameter int unsigned STREAM_WIDTH = node_net_pkg::DEF_STREAM_WIDTH,
  parameter int unsigned NET_WIDTH    = node_net_pkg::DEF_NET_WIDTH,
  parameter int unsigned MAX_FANOUT   = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned PAYLOAD_WIDTH = STREAM_WIDTH - NET_WIDTH,
  localparam int unsigned IDX_W         = $clog2(MAX_FANOUT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [IDX_W-1:0]         cfg_idx,
  input  logic [NET_WIDTH-1:0]     cfg_addr,
  input  logic                     cfg_cnt_we,
  input  logic [IDX_W:0]           cfg_cnt,
  output logic                     cfg_reject,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [STREAM_WIDTH-1:0]  out_stream,
  output logic                     busy,
`ifdef NODE_PACKETIZER_STATS_EN
  output logic [15:0]              sent_count,
`endif
  output logic                     drop_pulse
);

  import node_net_pkg::*;

  localparam int unsigned CNT_W = IDX_W + 1;

  tx_state_e                state, state_d;
  logic [NET_WIDTH-1:0]     dest_table [MAX_FANOUT];
  logic [CNT_W-1:0]         fan_cnt;
  logic [CNT_W-1:0]         cfg_cnt_sat;
  logic [CNT_W-1:0]         active_cnt, active_cnt_d;
  logic [IDX_W-1:0]         idx, idx_d, idx_inc;
  logic [PAYLOAD_WIDTH-1:0] payload_reg, payload_d;
  logic [PAYLOAD_WIDTH-1:0] fifo_rdata;
  logic [STREAM_WIDTH-1:0]  out_stream_d;
  logic                     out_valid_d;
  logic                     drop_d;
  logic                     pop;
  logic                     fifo_full, fifo_empty;
  logic                     fire, last;

  node_tx_fifo #(
    .WIDTH (PAYLOAD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop),
    .wdata (in_payload),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready    = ~fifo_full;
  assign busy        = (state != TX_IDLE) | ~fifo_empty;
  assign fire        = out_valid & out_ready;
  assign last        = (CNT_W'(idx) == active_cnt - CNT_W'(1));
  assign idx_inc     = idx + IDX_W'(1);
  assign cfg_cnt_sat = (cfg_cnt > CNT_W'(MAX_FANOUT)) ? CNT_W'(MAX_FANOUT) : cfg_cnt;

  // Configuration is frozen while any payload is queued or in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(MAX_FANOUT); i++) dest_table[i] <= '0;
      fan_cnt    <= '0;
      cfg_reject <= 1'b0;
    end else begin
      cfg_reject <= (cfg_we | cfg_cnt_we) & busy;
      if (!busy) begin
        if (cfg_we)     dest_table[cfg_idx] <= cfg_addr;
        if (cfg_cnt_we) fan_cnt <= cfg_cnt_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= TX_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      TX_IDLE: if (!fifo_empty && fan_cnt != '0) state_d = TX_EMIT;
      TX_EMIT: if (fire && last && fifo_empty)   state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
  end

  // Next values of the registered datapath and outputs; a new payload loads without a bubble.
  always_comb begin
    pop          = 1'b0;
    drop_d       = 1'b0;
    idx_d        = idx;
    active_cnt_d = active_cnt;
    payload_d    = payload_reg;
    out_valid_d  = out_valid;
    out_stream_d = out_stream;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (fan_cnt != '0) begin
            idx_d        = '0;
            active_cnt_d = fan_cnt;
            payload_d    = fifo_rdata;
            out_valid_d  = 1'b1;
            out_stream_d = pack_header(dest_table[0], fifo_rdata);
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      TX_EMIT: begin
        if (fire) begin
          if (!last) begin
            idx_d        = idx_inc;
            out_stream_d = pack_header(dest_table[idx_inc], payload_reg);
          end else if (!fifo_empty) begin
            pop          = 1'b1;
            idx_d        = '0;
            active_cnt_d = fan_cnt;
            payload_d    = fifo_rdata;
            out_stream_d = pack_header(dest_table[0], fifo_rdata);
          end else begin
            out_valid_d = 1'b0;
          end
        end
      end
      default: out_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      active_cnt  <= '0;
      payload_reg <= '0;
      out_valid   <= 1'b0;
      out_stream  <= '0;
      drop_pulse  <= 1'b0;
    end else begin
      idx         <= idx_d;
      active_cnt  <= active_cnt_d;
      payload_reg <= payload_d;
      out_valid   <= out_valid_d;
      out_stream  <= out_stream_d;
      drop_pulse  <= drop_d;
    end
  end

`ifdef NODE_PACKETIZER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)       sent_count <= '0;
    else if (fire) sent_count <= sent_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_node_packetizer.sv
// Directed self-checking bench for node_packetizer; covers sent_count when
// NODE_PACKETIZER_STATS_EN is defined.
module tb_node_packetizer;

  localparam int unsigned SW = 144;
  localparam int unsigned NW = 4;
  localparam int unsigned PW = SW - NW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_idx = '0;
  logic [NW-1:0] cfg_addr = '0;
  logic          cfg_cnt_we = 1'b0;
  logic [2:0]    cfg_cnt = '0;
  logic          cfg_reject;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_payload = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [SW-1:0] out_stream;
  logic          busy;
  logic          drop_pulse;
`ifdef NODE_PACKETIZER_STATS_EN
  logic [15:0]   sent_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  node_packetizer dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_addr   (cfg_addr),
    .cfg_cnt_we (cfg_cnt_we),
    .cfg_cnt    (cfg_cnt),
    .cfg_reject (cfg_reject),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_payload (in_payload),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_stream (out_stream),
    .busy       (busy),
`ifdef NODE_PACKETIZER_STATS_EN
    .sent_count (sent_count),
`endif
    .drop_pulse (drop_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [1:0] i, input logic [NW-1:0] a);
    cfg_we = 1'b1; cfg_idx = i; cfg_addr = a;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic write_cnt(input logic [2:0] c);
    cfg_cnt_we = 1'b1; cfg_cnt = c;
    tick();
    cfg_cnt_we = 1'b0;
  endtask

  task automatic push_one(input logic [PW-1:0] p);
    in_valid = 1'b1; in_payload = p;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_stream !== '0) begin bad++; $display("FAIL reset_out_stream got=%h exp=0", out_stream); end
    total++; if (cfg_reject !== 1'b0 || drop_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", cfg_reject, drop_pulse); end
    total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL reset_busy_ready got=%b%b exp=01", busy, in_ready); end
`ifdef NODE_PACKETIZER_STATS_EN
    total++; if (sent_count !== 16'd0) begin bad++; $display("FAIL reset_sent_count got=%0d exp=0", sent_count); end
`endif
  endtask

  task automatic test_single();
    logic [SW-1:0] exp_w;
    exp_w = {4'h9, PW'(140'h1234)};
    write_entry(2'd0, 4'h9);
    write_cnt(3'd1);
    out_ready = 1'b1;
    push_one(PW'(140'h1234));
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_latency_early got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_stream !== exp_w) begin bad++; $display("FAIL single_word got=%b/%h exp=1/%h", out_valid, out_stream, exp_w); end
    tick();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b%b exp=00", out_valid, busy); end
`ifdef NODE_PACKETIZER_STATS_EN
    total++; if (sent_count !== 16'd1) begin bad++; $display("FAIL single_sent_count got=%0d exp=1", sent_count); end
`endif
  endtask

  task automatic test_multicast();
    logic [PW-1:0] p;
    logic [SW-1:0] w1;
    p = PW'(140'hABCDEF);
    w1 = {4'h6, p};
    write_entry(2'd0, 4'h1);
    write_entry(2'd1, 4'h6);
    write_entry(2'd2, 4'hA);
    write_cnt(3'd3);
    push_one(p);
    tick();
    total++; if (out_valid !== 1'b1 || out_stream !== {4'h1, p}) begin bad++; $display("FAIL mc_word0 got=%b/%h exp=1/%h", out_valid, out_stream, {4'h1, p}); end
    tick();
    total++; if (out_valid !== 1'b1 || out_stream !== w1) begin bad++; $display("FAIL mc_word1 got=%b/%h exp=1/%h", out_valid, out_stream, w1); end
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_stream !== w1) begin bad++; $display("FAIL mc_stall%0d got=%b/%h exp=1/%h", i, out_valid, out_stream, w1); end
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || out_stream !== {4'hA, p}) begin bad++; $display("FAIL mc_word2 got=%b/%h exp=1/%h", out_valid, out_stream, {4'hA, p}); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mc_end got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] pl [5];
    logic [NW-1:0] hd [2];
    logic [SW-1:0] exp_w;
    hd[0] = 4'h1; hd[1] = 4'h6;
    for (int i = 0; i < 5; i++) pl[i] = PW'(140'h5000 + i);
    write_cnt(3'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_payload = pl[i];
      tick();
    end
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready got=%b exp=0", in_ready); end
    in_valid = 1'b1; in_payload = PW'(140'hDEAD);
    tick();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_still_full got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_w = {hd[i % 2], pl[i / 2]};
      total++; if (out_valid !== 1'b1 || out_stream !== exp_w) begin bad++; $display("FAIL b2b_word%0d got=%b/%h exp=1/%h", i, out_valid, out_stream, exp_w); end
      tick();
    end
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b%b exp=00", out_valid, busy); end
  endtask

  task automatic test_drop();
    int drops;
    int vseen;
    drops = 0; vseen = 0;
    write_cnt(3'd0);
    in_valid = 1'b1;
    in_payload = PW'(140'h77);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) in_payload = PW'(140'h88);
      if (i == 1) in_valid = 1'b0;
      if (drop_pulse === 1'b1) drops++;
      if (out_valid !== 1'b0) vseen++;
    end
    total++; if (drops !== 2) begin bad++; $display("FAIL drop_count got=%0d exp=2", drops); end
    total++; if (vseen !== 0) begin bad++; $display("FAIL drop_no_valid got=%0d exp=0", vseen); end
    total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL drop_empty got=%b%b exp=01", busy, in_ready); end
  endtask

  task automatic test_cfg_busy();
    logic [PW-1:0] p;
    logic [NW-1:0] hd [4];
    hd[0] = 4'h1; hd[1] = 4'h6; hd[2] = 4'hA; hd[3] = 4'h5;
    p = PW'(140'hC0FFEE);
    write_cnt(3'd3);
    out_ready = 1'b0;
    push_one(p);
    cfg_cnt_we = 1'b1; cfg_cnt = 3'd4;
    tick();
    cfg_cnt_we = 1'b0;
    total++; if (cfg_reject !== 1'b1) begin bad++; $display("FAIL cfg_reject_pulse got=%b exp=1", cfg_reject); end
    tick();
    total++; if (cfg_reject !== 1'b0) begin bad++; $display("FAIL cfg_reject_clear got=%b exp=0", cfg_reject); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b1 || out_stream !== {hd[i], p}) begin bad++; $display("FAIL cfg_busy_word%0d got=%b/%h exp=1/%h", i, out_valid, out_stream, {hd[i], p}); end
      tick();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL cfg_busy_cnt_kept got=%b exp=0", out_valid); end
    // Entry and count written together while idle; count 7 saturates to 4.
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_addr = 4'h5;
    cfg_cnt_we = 1'b1; cfg_cnt = 3'd7;
    tick();
    cfg_we = 1'b0; cfg_cnt_we = 1'b0;
    total++; if (cfg_reject !== 1'b0) begin bad++; $display("FAIL cfg_idle_accept got=%b exp=0", cfg_reject); end
    push_one(p);
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1 || out_stream !== {hd[i], p}) begin bad++; $display("FAIL cfg_sat_word%0d got=%b/%h exp=1/%h", i, out_valid, out_stream, {hd[i], p}); end
      tick();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL cfg_sat_end got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [PW-1:0] p;
    p = PW'(140'h4242);
    write_cnt(3'd3);
    out_ready = 1'b1;
    push_one(PW'(140'h9999));
    tick();
    tick();
    total++; if (out_valid !== 1'b1 || out_stream[SW-1 -: NW] !== 4'h6) begin bad++; $display("FAIL rstmid_word1 got=%b/%h exp=1/6", out_valid, out_stream[SW-1 -: NW]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_state got=%b%b%b exp=010", out_valid, in_ready, busy); end
`ifdef NODE_PACKETIZER_STATS_EN
    total++; if (sent_count !== 16'd0) begin bad++; $display("FAIL rstmid_sent_count got=%0d exp=0", sent_count); end
`endif
    write_cnt(3'd1);
    push_one(p);
    tick();
    total++; if (out_valid !== 1'b1 || out_stream !== {4'h0, p}) begin bad++; $display("FAIL rstmid_table_cleared got=%b/%h exp=1/%h", out_valid, out_stream, {4'h0, p}); end
    tick();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_end got=%b%b exp=00", out_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multicast();
    test_back_to_back();
    test_drop();
    test_cfg_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
